// File: rtl/sw_dispatch.sv
// Job dispatcher: loads a ref/read byte stream and a golden result, issues the job to
// the SW core, compares the core's result. Optional result watchdog: SW_DISPATCH_TIMEOUT_EN.
module sw_dispatch #(
    parameter int unsigned REF_MAX_LENGTH       = 256,
    parameter int unsigned READ_MAX_LENGTH      = 128,
    parameter int unsigned REF_LENGTH           = 128,
    parameter int unsigned READ_LENGTH          = 128,
    parameter int unsigned DP_SW_SCORE_BITWIDTH = 16,
    parameter int unsigned TIMEOUT_CYCLES       = 65535
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_byte_valid,
    input  logic [7:0]                            i_byte,
    output logic                                  o_byte_ready,
    input  logic                                  i_gold_valid,
    output logic                                  o_gold_ready,
    input  logic [DP_SW_SCORE_BITWIDTH-1:0]       i_gold_score,
    input  logic [$clog2(READ_MAX_LENGTH)-1:0]    i_gold_row,
    input  logic [$clog2(REF_MAX_LENGTH)-1:0]     i_gold_col,
    input  logic                                  i_core_ready,
    output logic                                  o_core_valid,
    output logic [2*REF_MAX_LENGTH-1:0]           o_sequence_ref,
    output logic [2*READ_MAX_LENGTH-1:0]          o_sequence_read,
    output logic [$clog2(REF_MAX_LENGTH):0]       o_seq_ref_length,
    output logic [$clog2(READ_MAX_LENGTH):0]      o_seq_read_length,
    output logic                                  o_core_result_ready,
    input  logic                                  i_core_valid,
    input  logic [DP_SW_SCORE_BITWIDTH-1:0]       i_core_score,
    input  logic [$clog2(READ_MAX_LENGTH)-1:0]    i_core_row,
    input  logic [$clog2(REF_MAX_LENGTH)-1:0]     i_core_column,
    output logic                                  o_busy,
    output logic                                  o_done,
    output logic                                  o_pass,
    output logic                                  o_timeout,
    output logic [15:0]                           o_job_cnt,
    output logic [15:0]                           o_err_cnt
);
    localparam int unsigned ROW_W      = $clog2(READ_MAX_LENGTH);
    localparam int unsigned COL_W      = $clog2(REF_MAX_LENGTH);
    localparam int unsigned SW         = DP_SW_SCORE_BITWIDTH;
    localparam int unsigned REF_BITS   = 2*REF_LENGTH;
    localparam int unsigned READ_BITS  = 2*READ_LENGTH;
    localparam int unsigned DATA_W     = REF_BITS + READ_BITS;
    localparam int unsigned NUM_BYTES  = DATA_W/8;
    localparam int unsigned BCNT_W     = $clog2(NUM_BYTES+1);
    localparam int unsigned SEQ_REF_W  = 2*REF_MAX_LENGTH;
    localparam int unsigned SEQ_READ_W = 2*READ_MAX_LENGTH;
    localparam int unsigned REF_LEN_W  = $clog2(REF_MAX_LENGTH)+1;
    localparam int unsigned READ_LEN_W = $clog2(READ_MAX_LENGTH)+1;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES+1);

    typedef enum logic [2:0] {
        S_LOAD, S_GOLD, S_WAIT_RDY, S_SETTLE, S_ISSUE, S_WAIT_RES, S_CHECK
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [BCNT_W-1:0]       r_bcnt, w_bcnt_nxt;
    logic [DATA_W-1:0]       r_data;
    logic [1:0]              r_settle;
    logic [SW-1:0]           r_gold_score, r_res_score;
    logic [ROW_W-1:0]        r_gold_row, r_res_row;
    logic [COL_W-1:0]        r_gold_col, r_res_col;
    logic                    r_byte_ready, r_gold_ready, r_core_valid, r_res_ready;
    logic [SEQ_REF_W-1:0]    r_seq_ref;
    logic [SEQ_READ_W-1:0]   r_seq_read;
    logic [REF_LEN_W-1:0]    r_ref_len;
    logic [READ_LEN_W-1:0]   r_read_len;
    logic                    r_busy, r_done, r_pass, r_timeout;
    logic [15:0]             r_job_cnt, r_err_cnt;
    logic                    w_byte_acc, w_match, w_issue_nxt;
    logic [SEQ_REF_W-1:0]    w_ref_pad;
    logic [SEQ_READ_W-1:0]   w_read_pad;
`ifdef SW_DISPATCH_TIMEOUT_EN
    logic [TO_W-1:0]         r_to_cnt;
    logic                    w_timeout_hit;
`else
    logic                    w_unused_to;
    assign w_unused_to = |TO_W'(TIMEOUT_CYCLES);
`endif

    // Job data is left-aligned in the max-length buses, zero padded below
    assign w_ref_pad   = SEQ_REF_W'(r_data[DATA_W-1 -: REF_BITS]) << (SEQ_REF_W - REF_BITS);
    assign w_read_pad  = SEQ_READ_W'(r_data[READ_BITS-1:0]) << (SEQ_READ_W - READ_BITS);
    assign w_match     = ($signed(r_res_score) == $signed(r_gold_score)) &&
                         (r_res_row == r_gold_row) && (r_res_col == r_gold_col);
    assign w_byte_acc  = r_byte_ready && i_byte_valid;
    assign w_issue_nxt = (w_state_nxt == S_ISSUE);

    always_ff @(posedge clk) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bcnt_nxt  = r_bcnt;
`ifdef SW_DISPATCH_TIMEOUT_EN
        w_timeout_hit = 1'b0;
`endif
        case (r_state)
            S_LOAD: begin
                if (w_byte_acc) begin
                    if (r_bcnt == BCNT_W'(NUM_BYTES-1)) begin
                        w_bcnt_nxt  = '0;
                        w_state_nxt = S_GOLD;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BCNT_W'(1);
                    end
                end
            end
            S_GOLD:     if (i_gold_valid) w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: if (i_core_ready) w_state_nxt = S_SETTLE;
            S_SETTLE:   if (r_settle == 2'd3) w_state_nxt = S_ISSUE;
            S_ISSUE:    w_state_nxt = S_WAIT_RES;
            S_WAIT_RES: begin
                if (i_core_valid) begin
                    w_state_nxt = S_CHECK;
                end
`ifdef SW_DISPATCH_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES-1)) begin
                    w_timeout_hit = 1'b1;
                    w_state_nxt   = S_LOAD;
                end
`endif
            end
            S_CHECK:    w_state_nxt = S_LOAD;
            default:    w_state_nxt = S_LOAD;
        endcase
    end

    // Datapath and registered outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_bcnt <= '0;            r_data <= '0;           r_settle <= '0;
            r_gold_score <= '0;      r_gold_row <= '0;       r_gold_col <= '0;
            r_res_score <= '0;       r_res_row <= '0;        r_res_col <= '0;
            r_byte_ready <= 1'b0;    r_gold_ready <= 1'b0;   r_core_valid <= 1'b0;
            r_res_ready <= 1'b0;     r_seq_ref <= '0;        r_seq_read <= '0;
            r_ref_len <= '0;         r_read_len <= '0;       r_busy <= 1'b0;
            r_done <= 1'b0;          r_pass <= 1'b0;         r_timeout <= 1'b0;
            r_job_cnt <= '0;         r_err_cnt <= '0;
`ifdef SW_DISPATCH_TIMEOUT_EN
            r_to_cnt <= '0;
`endif
        end else begin
            r_bcnt <= w_bcnt_nxt;
            if (w_byte_acc) r_data <= {r_data[DATA_W-9:0], i_byte};
            if (r_state == S_GOLD && i_gold_valid) begin
                r_gold_score <= i_gold_score;
                r_gold_row   <= i_gold_row;
                r_gold_col   <= i_gold_col;
            end
            r_settle <= (r_state == S_SETTLE) ? r_settle + 2'd1 : 2'd0;
            if (r_state == S_WAIT_RES && i_core_valid) begin
                r_res_score <= i_core_score;
                r_res_row   <= i_core_row;
                r_res_col   <= i_core_column;
            end
            r_byte_ready <= (w_state_nxt == S_LOAD);
            r_gold_ready <= (w_state_nxt == S_GOLD);
            r_res_ready  <= (w_state_nxt == S_WAIT_RES);
            r_core_valid <= w_issue_nxt;
            r_seq_ref    <= w_issue_nxt ? w_ref_pad  : '0;
            r_seq_read   <= w_issue_nxt ? w_read_pad : '0;
            r_ref_len    <= w_issue_nxt ? REF_LEN_W'(REF_LENGTH)   : '0;
            r_read_len   <= w_issue_nxt ? READ_LEN_W'(READ_LENGTH) : '0;
            r_busy       <= !((w_state_nxt == S_LOAD) && (w_bcnt_nxt == '0));
            r_done       <= 1'b0;
            if (r_state == S_CHECK) begin
                r_done <= 1'b1;
                r_pass <= w_match;
                if (r_job_cnt != 16'hFFFF) r_job_cnt <= r_job_cnt + 16'd1;
                if (!w_match && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
`ifdef SW_DISPATCH_TIMEOUT_EN
            r_to_cnt <= (r_state == S_WAIT_RES) ? r_to_cnt + TO_W'(1) : '0;
            if (w_timeout_hit) begin
                r_done    <= 1'b1;
                r_pass    <= 1'b0;
                r_timeout <= 1'b1;
                if (r_job_cnt != 16'hFFFF) r_job_cnt <= r_job_cnt + 16'd1;
                if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
            end
`endif
        end
    end

    assign o_byte_ready        = r_byte_ready;
    assign o_gold_ready        = r_gold_ready;
    assign o_core_valid        = r_core_valid;
    assign o_sequence_ref      = r_seq_ref;
    assign o_sequence_read     = r_seq_read;
    assign o_seq_ref_length    = r_ref_len;
    assign o_seq_read_length   = r_read_len;
    assign o_core_result_ready = r_res_ready;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
    assign o_pass              = r_pass;
    assign o_timeout           = r_timeout;
    assign o_job_cnt           = r_job_cnt;
    assign o_err_cnt           = r_err_cnt;

endmodule

// File: tb/tb_sw_dispatch.sv
// Self-checking bench for sw_dispatch: directed and randomized jobs against a byte-level
// model; the watchdog scenario depends on SW_DISPATCH_TIMEOUT_EN.
module tb_sw_dispatch;
    localparam int unsigned REF_MAX  = 256;
    localparam int unsigned READ_MAX = 128;
    localparam int unsigned REF_LEN  = 128;
    localparam int unsigned READ_LEN = 128;
    localparam int unsigned SW       = 16;
    localparam int unsigned TO       = 100;
    localparam int unsigned ROW_W    = $clog2(READ_MAX);
    localparam int unsigned COL_W    = $clog2(REF_MAX);
    localparam int unsigned NREF     = 2*REF_LEN/8;
    localparam int unsigned NREAD    = 2*READ_LEN/8;
    localparam int unsigned NB       = NREF + NREAD;

    logic clk = 1'b0;
    logic rst;
    logic i_byte_valid, o_byte_ready, i_gold_valid, o_gold_ready;
    logic [7:0] i_byte;
    logic [SW-1:0] i_gold_score, i_core_score;
    logic [ROW_W-1:0] i_gold_row, i_core_row;
    logic [COL_W-1:0] i_gold_col, i_core_column;
    logic i_core_ready, o_core_valid, o_core_result_ready, i_core_valid;
    logic [2*REF_MAX-1:0] o_sequence_ref;
    logic [2*READ_MAX-1:0] o_sequence_read;
    logic [$clog2(REF_MAX):0] o_seq_ref_length;
    logic [$clog2(READ_MAX):0] o_seq_read_length;
    logic o_busy, o_done, o_pass, o_timeout;
    logic [15:0] o_job_cnt, o_err_cnt;

    sw_dispatch #(
        .REF_MAX_LENGTH(REF_MAX), .READ_MAX_LENGTH(READ_MAX), .REF_LENGTH(REF_LEN),
        .READ_LENGTH(READ_LEN), .DP_SW_SCORE_BITWIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_byte_valid(i_byte_valid), .i_byte(i_byte), .o_byte_ready(o_byte_ready),
        .i_gold_valid(i_gold_valid), .o_gold_ready(o_gold_ready),
        .i_gold_score(i_gold_score), .i_gold_row(i_gold_row), .i_gold_col(i_gold_col),
        .i_core_ready(i_core_ready), .o_core_valid(o_core_valid),
        .o_sequence_ref(o_sequence_ref), .o_sequence_read(o_sequence_read),
        .o_seq_ref_length(o_seq_ref_length), .o_seq_read_length(o_seq_read_length),
        .o_core_result_ready(o_core_result_ready), .i_core_valid(i_core_valid),
        .i_core_score(i_core_score), .i_core_row(i_core_row), .i_core_column(i_core_column),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_job_cnt(o_job_cnt), .o_err_cnt(o_err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exp_jobs = 0;
    int exp_errs = 0;
    bit exp_timeout = 1'b0;
    logic [7:0] job_bytes [NB];

    function automatic logic [2*REF_MAX-1:0] exp_ref_seq();
        logic [2*REF_MAX-1:0] v = '0;
        for (int i = 0; i < int'(NREF); i++) v[2*REF_MAX-1-8*i -: 8] = job_bytes[i];
        return v;
    endfunction

    function automatic logic [2*READ_MAX-1:0] exp_read_seq();
        logic [2*READ_MAX-1:0] v = '0;
        for (int i = 0; i < int'(NREAD); i++) v[2*READ_MAX-1-8*i -: 8] = job_bytes[NREF+i];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int g = 0;
        if (stall) repeat ($urandom_range(0, 2)) begin
            i_byte_valid = 1'b0;
            @(negedge clk);
        end
        i_byte_valid = 1'b1;
        i_byte = b;
        while (o_byte_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin
            checks++; errors++;
            $display("FAIL byte_handshake: o_byte_ready=%0b required 1", o_byte_ready);
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic send_gold(input logic [SW-1:0] s, input logic [ROW_W-1:0] r,
                             input logic [COL_W-1:0] c);
        int g = 0;
        i_gold_valid = 1'b1; i_gold_score = s; i_gold_row = r; i_gold_col = c;
        while (o_gold_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin
            checks++; errors++;
            $display("FAIL gold_handshake: o_gold_ready=%0b required 1", o_gold_ready);
        end
        @(negedge clk);
        i_gold_valid = 1'b0;
    endtask

    // One complete job; respond=0 withholds the core result
    task automatic run_job(input logic [SW-1:0] gs, input logic [ROW_W-1:0] gr,
                           input logic [COL_W-1:0] gc, input logic [SW-1:0] cs,
                           input logic [ROW_W-1:0] cr, input logic [COL_W-1:0] cc,
                           input bit stall, input int rdy_delay, input bit respond);
        int n;
        int lim;
        bit early;
        bit pass_exp;
        bit timed_out = 1'b0;
        i_core_ready = (rdy_delay == 0);
        for (int i = 0; i < int'(NB); i++) send_byte(job_bytes[i], stall);
        send_gold(gs, gr, gc);
        if (rdy_delay > 0) begin
            early = 1'b0;
            i_core_valid = 1'b1; i_core_score = ~cs; i_core_row = ~cr; i_core_column = ~cc;
            repeat (rdy_delay) begin
                if (o_core_valid !== 1'b0) early = 1'b1;
                @(negedge clk);
            end
            i_core_valid = 1'b0;
            checks++;
            if (early) begin errors++; $display("FAIL early_issue: o_core_valid seen 1 required 0"); end
            i_core_ready = 1'b1;
            n = 0;
            while (o_core_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            checks++;
            if (n != 5) begin errors++; $display("FAIL issue_latency: %0d cycles required 5", n); end
        end else begin
            n = 0;
            while (o_core_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            checks++;
            if (n >= 50) begin errors++; $display("FAIL issue_wait: o_core_valid never 1"); end
        end
        checks++;
        if (o_sequence_ref !== exp_ref_seq()) begin
            errors++; $display("FAIL seq_ref: got %0h required %0h", o_sequence_ref, exp_ref_seq());
        end
        checks++;
        if (o_sequence_read !== exp_read_seq()) begin
            errors++; $display("FAIL seq_read: got %0h required %0h", o_sequence_read, exp_read_seq());
        end
        checks++;
        if (o_seq_ref_length !== 9'(REF_LEN) || o_seq_read_length !== 8'(READ_LEN)) begin
            errors++; $display("FAIL lengths: got %0d/%0d required %0d/%0d",
                               o_seq_ref_length, o_seq_read_length, REF_LEN, READ_LEN);
        end
        @(negedge clk);
        checks++;
        if (o_core_valid !== 1'b0 || o_sequence_ref !== '0 || o_sequence_read !== '0 ||
            o_seq_ref_length !== '0 || o_seq_read_length !== '0 || o_busy !== 1'b1) begin
            errors++; $display("FAIL post_issue: valid=%0b ref_len=%0d busy=%0b required 0/0/1",
                               o_core_valid, o_seq_ref_length, o_busy);
        end
        if (respond) begin
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end else begin
`ifdef SW_DISPATCH_TIMEOUT_EN
            timed_out = 1'b1;
`else
            repeat (200) @(negedge clk);
            checks++;
            if (o_timeout !== 1'b0 || o_done !== 1'b0 || o_core_result_ready !== 1'b1) begin
                errors++; $display("FAIL no_watchdog: timeout=%0b done=%0b rdy=%0b required 0/0/1",
                                   o_timeout, o_done, o_core_result_ready);
            end
`endif
        end
        if (!timed_out) begin
            i_core_valid = 1'b1; i_core_score = cs; i_core_row = cr; i_core_column = cc;
            n = 0;
            while (o_core_result_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) begin
                checks++; errors++; $display("FAIL result_handshake: ready never 1");
            end
            @(negedge clk);
            i_core_valid = 1'b0;
        end
        pass_exp = !timed_out && (cs == gs) && (cr == gr) && (cc == gc);
        if (timed_out) exp_timeout = 1'b1;
        if (exp_jobs < 65535) exp_jobs++;
        if (!pass_exp && exp_errs < 65535) exp_errs++;
        lim = timed_out ? int'(TO) + 20 : 20;
        n = 0;
        while (o_done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
        checks++;
        if (n >= lim) begin errors++; $display("FAIL done_wait: o_done never 1"); end
        if (timed_out) begin
            checks++;
            if (n < int'(TO) || n > int'(TO) + 3) begin
                errors++; $display("FAIL timeout_latency: %0d cycles required about %0d", n, TO);
            end
        end
        checks++;
        if (o_pass !== pass_exp) begin
            errors++; $display("FAIL pass: got %0b required %0b", o_pass, pass_exp);
        end
        checks++;
        if (o_job_cnt !== 16'(exp_jobs) || o_err_cnt !== 16'(exp_errs)) begin
            errors++; $display("FAIL counters: jobs=%0d errs=%0d required %0d/%0d",
                               o_job_cnt, o_err_cnt, exp_jobs, exp_errs);
        end
        checks++;
        if (o_timeout !== exp_timeout || o_busy !== 1'b0) begin
            errors++; $display("FAIL status: timeout=%0b busy=%0b required %0b/0",
                               o_timeout, o_busy, exp_timeout);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0 || o_byte_ready !== 1'b1) begin
            errors++; $display("FAIL done_pulse: done=%0b byte_ready=%0b required 0/1", o_done, o_byte_ready);
        end
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < int'(NB); i++) job_bytes[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < int'(NB); i++) job_bytes[i] = 8'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_byte_ready !== 1'b0 || o_gold_ready !== 1'b0 || o_core_valid !== 1'b0 ||
            o_core_result_ready !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 ||
            o_pass !== 1'b0 || o_timeout !== 1'b0 || o_sequence_ref !== '0) begin
            errors++; $display("FAIL reset_outputs: ready=%0b busy=%0b done=%0b required all 0",
                               o_byte_ready, o_busy, o_done);
        end
        checks++;
        if (o_job_cnt !== 16'd0 || o_err_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters: %0d/%0d required 0/0", o_job_cnt, o_err_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_byte_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++; $display("FAIL idle: byte_ready=%0b busy=%0b required 1/0", o_byte_ready, o_busy);
        end
    endtask

    task automatic test_basic_pass();
        fill_ramp();
        run_job(16'd12, 7'd5, 8'd7, 16'd12, 7'd5, 8'd7, 1'b0, 0, 1'b1);
    endtask

    task automatic test_mismatch();
        fill_ramp();
        run_job(16'd12, 7'd5, 8'd7, 16'd12, 7'd5, 8'd8, 1'b0, 0, 1'b1);
    endtask

    task automatic test_ready_delay();
        fill_random();
        run_job(16'd300, 7'd100, 8'd200, 16'd300, 7'd100, 8'd200, 1'b0, 20, 1'b1);
    endtask

    task automatic test_negative();
        fill_random();
        run_job(SW'(-5), 7'd3, 8'd9, SW'(-5), 7'd3, 8'd9, 1'b1, 0, 1'b1);
        fill_random();
        run_job(16'd5, 7'd3, 8'd9, SW'(-5), 7'd3, 8'd9, 1'b1, 0, 1'b1);
    endtask

    task automatic test_random();
        logic [SW-1:0] gs, cs;
        logic [ROW_W-1:0] gr, cr;
        logic [COL_W-1:0] gc, cc;
        for (int j = 0; j < 8; j++) begin
            fill_random();
            gs = SW'($urandom); gr = ROW_W'($urandom); gc = COL_W'($urandom);
            cs = gs; cr = gr; cc = gc;
            case ($urandom_range(0, 3))
                1: cs = gs ^ SW'($urandom_range(1, 65535));
                2: cr = gr + ROW_W'(1);
                3: cc = gc + COL_W'(1);
                default: ;
            endcase
            run_job(gs, gr, gc, cs, cr, cc, bit'($urandom_range(0, 1)), 0, 1'b1);
        end
    endtask

    task automatic test_timeout();
        fill_random();
        run_job(16'd1, 7'd2, 8'd3, 16'd1, 7'd2, 8'd3, 1'b0, 0, 1'b0);
        fill_random();
        run_job(16'd4, 7'd5, 8'd6, 16'd4, 7'd5, 8'd6, 1'b1, 0, 1'b1);
    endtask

    task automatic test_midjob_reset();
        fill_random();
        for (int i = 0; i < 30; i++) send_byte(job_bytes[i], 1'b0);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL midjob_busy: got %0b required 1", o_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        exp_jobs = 0; exp_errs = 0; exp_timeout = 1'b0;
        checks++;
        if (o_job_cnt !== 16'd0 || o_err_cnt !== 16'd0 || o_busy !== 1'b0 || o_timeout !== 1'b0) begin
            errors++; $display("FAIL midjob_reset: jobs=%0d errs=%0d busy=%0b required 0/0/0",
                               o_job_cnt, o_err_cnt, o_busy);
        end
        rst = 1'b1;
        @(negedge clk);
        fill_ramp();
        run_job(16'd12, 7'd5, 8'd7, 16'd12, 7'd5, 8'd7, 1'b0, 0, 1'b1);
    endtask

    initial begin
        rst = 1'b0;
        i_byte_valid = 1'b0; i_byte = '0;
        i_gold_valid = 1'b0; i_gold_score = '0; i_gold_row = '0; i_gold_col = '0;
        i_core_ready = 1'b0; i_core_valid = 1'b0;
        i_core_score = '0; i_core_row = '0; i_core_column = '0;
        @(negedge clk);
        test_reset();
        test_basic_pass();
        test_mismatch();
        test_ready_delay();
        test_negative();
        test_random();
        test_timeout();
        test_midjob_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sw_dispatch.md
SW_DISPATCH -- requirements
Module: sw_dispatch

Interface
REQ-001 Parameters (name, default, meaning): REF_MAX_LENGTH, 256, max ref bases; READ_MAX_LENGTH, 128, max read bases; REF_LENGTH, 128, ref bases per job; READ_LENGTH, 128, read bases per job; DP_SW_SCORE_BITWIDTH, 16, score width; TIMEOUT_CYCLES, 65535, result watchdog limit.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- rst, in, 1, synchronous, active-low reset.
- i_byte_valid / i_byte / o_byte_ready, in/in/out, 1/8/1: job byte stream, 2*REF_LENGTH/8 ref bytes then 2*READ_LENGTH/8 read bytes.
- i_gold_valid / o_gold_ready, in/out, 1/1: golden-result handshake.
- i_gold_score / i_gold_row / i_gold_col, in, DP_SW_SCORE_BITWIDTH / clog2(READ_MAX_LENGTH) / clog2(REF_MAX_LENGTH): golden values.
- i_core_ready, in, 1: core can accept a job.
- o_core_valid, out, 1: job-issue strobe.
- o_sequence_ref / o_sequence_read, out, 2*REF_MAX_LENGTH / 2*READ_MAX_LENGTH: packed sequences.
- o_seq_ref_length / o_seq_read_length, out, clog2(MAX)+1 each: 1-based lengths.
- o_core_result_ready, out, 1: accepts core result.
- i_core_valid / i_core_score / i_core_row / i_core_column, in, widths as golden: core result.
- o_busy, o_done, o_pass, o_timeout, out, 1 each: status.
- o_job_cnt / o_err_cnt, out, 16 each: counters.

Function
REQ-003 States: S_LOAD, S_GOLD, S_WAIT_RDY, S_SETTLE, S_ISSUE, S_WAIT_RES, S_CHECK.
REQ-004 S_LOAD: o_byte_ready=1; each accepted byte shifts in at LSB, so first byte ends as MSB of ref; byte counter to ref+read byte total; last byte accepted -> S_GOLD.
REQ-005 S_GOLD: o_gold_ready=1; on i_gold_valid latch score/row/col -> S_WAIT_RDY.
REQ-006 S_WAIT_RDY: wait i_core_ready=1 -> S_SETTLE; S_SETTLE holds exactly 4 cycles -> S_ISSUE.
REQ-007 S_ISSUE: o_core_valid=1 exactly one cycle; o_sequence_ref = {ref data, (2*REF_MAX_LENGTH-2*REF_LENGTH) zeros}; read likewise; lengths = REF_LENGTH/READ_LENGTH; -> S_WAIT_RES.
REQ-008 Outside S_ISSUE, o_core_valid, sequences and lengths SHALL be 0.
REQ-009 S_WAIT_RES: o_core_result_ready=1; i_core_valid latches score/row/column -> S_CHECK; i_core_valid in any other state ignored.
REQ-010 S_CHECK (1 cycle): pass iff score, row, column all equal golden; o_job_cnt+1; o_err_cnt+1 on mismatch; o_pass = result; o_done pulses 1 cycle; -> S_LOAD.
REQ-011 Counters saturate at 16'hFFFF.
REQ-012 o_busy=1 in every state except S_LOAD with byte counter 0.
REQ-013 Score compare signed, full DP_SW_SCORE_BITWIDTH.

Reset
REQ-014 rst=0 at a clk edge -> S_LOAD, byte counter 0, all outputs 0, o_job_cnt=o_err_cnt=0, latched data cleared.
REQ-015 Reset mid-job (any state) abandons the job with no counter change; first post-reset byte is ref MSB.

Configuration
REQ-016 SW_DISPATCH_TIMEOUT_EN defined: counter runs in S_WAIT_RES; TIMEOUT_CYCLES cycles without i_core_valid -> o_err_cnt+1, o_job_cnt+1, o_timeout sticky 1 until reset, o_done pulse with o_pass=0, -> S_LOAD.
REQ-017 SW_DISPATCH_TIMEOUT_EN undefined: S_WAIT_RES waits indefinitely; o_timeout tied 0.

Verification
REQ-018 64 bytes (ref 0x00..0x1F, read 0x20..0x3F), golden (12,5,7), core returns (12,5,7) -> o_sequence_ref[511:504]=0x00, low 256 bits 0, o_pass=1, o_job_cnt=1, o_err_cnt=0.
REQ-019 Same job, core returns (12,5,8) -> o_pass=0, o_err_cnt=1.
REQ-020 i_core_ready held 0 20 cycles then 1 -> o_core_valid rises exactly 5 cycles after ready seen, 1-cycle wide.
REQ-021 rst=0 after 30 bytes loaded -> counters 0; fresh 64-byte job completes correctly.
REQ-022 SW_DISPATCH_TIMEOUT_EN, TIMEOUT_CYCLES=100, no i_core_valid -> after 100 cycles o_timeout=1, o_err_cnt=1, FSM in S_LOAD.
REQ-023 Negative golden -5, core -5 -> o_pass=1; byte-stream stalls (i_byte_valid gaps) do not corrupt data.
